// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative IEEE-754-style multiplier, shift-add mantissa, RNE.
// Ports: clk, reset(sync, low), en/num1/num2 in; res/val/busy/flags out.
`timescale 1ns/1ps
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [EXP_W+MAN_W:0]       num1,
    input  logic [EXP_W+MAN_W:0]       num2,
    output logic [EXP_W+MAN_W:0]       res,
    output logic                       val,
    output logic                       busy,
    output logic [3:0]                 flags
);
    localparam int M    = MAN_W + 1;
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int CW   = $clog2(M);
    localparam int EW   = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, RND} state_t;
    state_t state, state_nx;

    // operand decode
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero_c, a_inf_c, a_nan_c, a_snan_c;
    logic             b_zero_c, b_inf_c, b_nan_c, b_snan_c;
    logic signed [EW-1:0] e_c;

    assign ea = num1[W-2:MAN_W];
    assign eb = num2[W-2:MAN_W];
    assign fa = num1[MAN_W-1:0];
    assign fb = num2[MAN_W-1:0];

    assign a_zero_c = (ea == '0);
    assign a_inf_c  = (&ea) && (fa == '0);
    assign a_nan_c  = (&ea) && (fa != '0);
    assign a_snan_c = a_nan_c && !fa[MAN_W-1];
    assign b_zero_c = (eb == '0);
    assign b_inf_c  = (&eb) && (fb == '0);
    assign b_nan_c  = (&eb) && (fb != '0);
    assign b_snan_c = b_nan_c && !fb[MAN_W-1];

    assign e_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;

    // registered operation state
    logic [2*M-1:0]       mcand;
    logic [M-1:0]         mpl;
    logic [2*M-1:0]       acc;
    logic [CW-1:0]        cnt;
    logic signed [EW-1:0] e_r;
    logic                 sgn;
    logic                 a_zero, a_inf, a_nan, a_snan;
    logic                 b_zero, b_inf, b_nan, b_snan;

    // rounding / result selection
    logic                 top;
    logic [2*M-2:0]       norm;
    logic [MAN_W-1:0]     frac;
    logic                 g, r, s, inc;
    logic [MAN_W:0]       frac_inc;
    logic signed [EW-1:0] e_fin;
    logic [W-1:0]         res_c;
    logic [3:0]           flags_c;
    logic                 any_nan, inf_zero;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (en) state_nx = MUL;
            MUL:  if (cnt == CW'(M - 1)) state_nx = RND;
            RND:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // hidden bit sits at 2M-1 or 2M-2; norm drops it
    always_comb begin
        top      = acc[2*M-1];
        norm     = top ? acc[2*M-2:0] : {acc[2*M-3:0], 1'b0};
        frac     = norm[2*M-2:M];
        g        = norm[M-1];
        r        = norm[M-2];
        s        = |norm[M-3:0];
        inc      = g & (r | s | frac[0]);
        frac_inc = {1'b0, frac} + (MAN_W+1)'(inc);
        e_fin    = e_r + EW'(top) + EW'(frac_inc[MAN_W]);
    end

    always_comb begin
        any_nan  = a_nan | b_nan;
        inf_zero = (a_inf & b_zero) | (b_inf & a_zero);
        res_c    = '0;
        flags_c  = '0;
        if (any_nan || inf_zero) begin
            res_c      = QNAN;
            flags_c[3] = inf_zero | a_snan | b_snan;
        end else if (a_inf || b_inf) begin
            res_c = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            res_c = {sgn, {(W-1){1'b0}}};
        end else if (e_fin >= E_MAX) begin
            res_c   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c = 4'b0101;
        end else if (e_fin <= E_ZERO) begin
            res_c   = {sgn, {(W-1){1'b0}}};
            flags_c = 4'b0011;
        end else begin
            // carry-out leaves frac_inc low bits at zero
            res_c      = {sgn, e_fin[EXP_W-1:0], frac_inc[MAN_W-1:0]};
            flags_c[0] = g | r | s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand  <= '0;
            mpl    <= '0;
            acc    <= '0;
            cnt    <= '0;
            e_r    <= '0;
            sgn    <= 1'b0;
            a_zero <= 1'b0;
            a_inf  <= 1'b0;
            a_nan  <= 1'b0;
            a_snan <= 1'b0;
            b_zero <= 1'b0;
            b_inf  <= 1'b0;
            b_nan  <= 1'b0;
            b_snan <= 1'b0;
            res    <= '0;
            flags  <= '0;
            val    <= 1'b0;
        end else begin
            val <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        mcand  <= {{M{1'b0}}, 1'b1, fa};
                        mpl    <= {1'b1, fb};
                        acc    <= '0;
                        cnt    <= '0;
                        e_r    <= e_c;
                        sgn    <= num1[W-1] ^ num2[W-1];
                        a_zero <= a_zero_c;
                        a_inf  <= a_inf_c;
                        a_nan  <= a_nan_c;
                        a_snan <= a_snan_c;
                        b_zero <= b_zero_c;
                        b_inf  <= b_inf_c;
                        b_nan  <= b_nan_c;
                        b_snan <= b_snan_c;
                    end
                end
                MUL: begin
                    acc   <= acc + (mpl[0] ? mcand : '0);
                    mcand <= mcand << 1;
                    mpl   <= mpl >> 1;
                    cnt   <= cnt + CW'(1);
                end
                RND: begin
                    res   <= res_c;
                    flags <= flags_c;
                    val   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vectors for fp_mul_seq (single and half formats).
// Checks results, flags, latency, handshake and mid-op reset.
`timescale 1ns/1ps
module tb_fp_mul_seq;
    logic        clk = 0;
    logic        rst;
    logic        en, h_en;
    logic [31:0] n1, n2, res;
    logic [15:0] h_n1, h_n2, h_res;
    logic        val, busy, h_val, h_busy;
    logic [3:0]  flags, h_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_seq dut (
        .clk(clk), .reset(rst), .en(en), .num1(n1), .num2(n2),
        .res(res), .val(val), .busy(busy), .flags(flags)
    );

    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(rst), .en(h_en), .num1(h_n1), .num2(h_n2),
        .res(h_res), .val(h_val), .busy(h_busy), .flags(h_flags)
    );

    typedef struct {
        bit          half;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic run_op(input bit half, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output logic [3:0] f, output int lat);
        @(negedge clk);
        if (half) begin
            h_en = 1; h_n1 = a[15:0]; h_n2 = b[15:0];
        end else begin
            en = 1; n1 = a; n2 = b;
        end
        @(posedge clk); #1;
        en = 0; h_en = 0;
        n1 = '0; n2 = '0; h_n1 = '0; h_n2 = '0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (half ? h_val : val) begin
                lat = k;
                break;
            end
        end
        r = half ? {16'h0, h_res} : res;
        f = half ? h_flags : flags;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        int          nval;
        int          vpos [4];
        string       nm;

        tbl[0]  = '{1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0};
        tbl[1]  = '{1'b0, 32'hC0000000, 32'h3F000000, 32'hBF800000, 4'h0};
        tbl[2]  = '{1'b0, 32'h3F800800, 32'h3F800800, 32'h3F801000, 4'h1};
        tbl[3]  = '{1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1};
        tbl[4]  = '{1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5};
        tbl[5]  = '{1'b0, 32'h0D800000, 32'h0D800000, 32'h00000000, 4'h3};
        tbl[6]  = '{1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8};
        tbl[7]  = '{1'b0, 32'h80000000, 32'h3F800000, 32'h80000000, 4'h0};
        tbl[8]  = '{1'b0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1};
        tbl[9]  = '{1'b0, 32'h3F800001, 32'h3FFFFFFF, 32'h40000000, 4'h1};
        tbl[10] = '{1'b0, 32'h7F000000, 32'h3F800000, 32'h7F000000, 4'h0};
        tbl[11] = '{1'b0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5};
        tbl[12] = '{1'b0, 32'h20000000, 32'h1F800000, 32'h00000000, 4'h3};
        tbl[13] = '{1'b0, 32'h20000000, 32'h20000000, 32'h00800000, 4'h0};
        tbl[14] = '{1'b0, 32'h7F800000, 32'hC0000000, 32'hFF800000, 4'h0};
        tbl[15] = '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8};
        tbl[16] = '{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0};
        tbl[17] = '{1'b0, 32'hFF800000, 32'hFF800000, 32'h7F800000, 4'h0};
        tbl[18] = '{1'b1, 32'h00003E00, 32'h00004000, 32'h00004200, 4'h0};
        tbl[19] = '{1'b1, 32'h00007BFF, 32'h00004000, 32'h00007C00, 4'h5};

        rst = 0; en = 0; h_en = 0;
        n1 = '0; n2 = '0; h_n1 = '0; h_n2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res", res, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_val", {31'h0, val}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_h_res", {16'h0, h_res}, 32'h0);
        rst = 1;

        for (int i = 0; i < 20; i++) begin
            run_op(tbl[i].half, tbl[i].a, tbl[i].b, r, f, lat);
            nm = $sformatf("vec%0d_res", i);
            chk(nm, r, tbl[i].r);
            nm = $sformatf("vec%0d_flags", i);
            chk(nm, {28'h0, f}, {28'h0, tbl[i].f});
            nm = $sformatf("vec%0d_lat", i);
            chk(nm, lat, tbl[i].half ? 12 : 25);
        end

        // en held high: accepts only at idle edges, val every 26 edges
        @(negedge clk);
        en = 1; n1 = 32'h3FC00000; n2 = 32'h40000000;
        nval = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k == 1)  chk("b2b_busy1", {31'h0, busy}, 32'h1);
            if (k == 26) chk("b2b_busy26", {31'h0, busy}, 32'h0);
            if (k == 40) chk("b2b_hold", res, 32'h40400000);
            if (val) begin
                if (nval < 4) vpos[nval] = k;
                nval++;
                chk("b2b_res", res, 32'h40400000);
            end
        end
        en = 0;
        chk("b2b_count", nval, 3);
        chk("b2b_pos0", vpos[0], 26);
        chk("b2b_pos1", vpos[1], 52);
        chk("b2b_pos2", vpos[2], 78);
        for (int k = 0; k < 40 && busy; k++) @(posedge clk);
        chk("b2b_drain", {31'h0, busy}, 32'h0);

        // reset mid-operation at edge t+10
        @(negedge clk);
        en = 1; n1 = 32'h40000000; n2 = 32'h40000000;
        @(posedge clk); #1;
        en = 0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("mid_rst_res", res, 32'h0);
        chk("mid_rst_flags", {28'h0, flags}, 32'h0);
        chk("mid_rst_val", {31'h0, val}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1;
        nval = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (val) nval++;
        end
        chk("mid_rst_noval", nval, 0);
        run_op(1'b0, 32'h40000000, 32'h40400000, r, f, lat);
        chk("post_rst_res", r, 32'h40C00000);
        chk("post_rst_flags", {28'h0, f}, 32'h0);
        chk("post_rst_lat", lat, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Parametrised, iterative IEEE-754-style floating-point multiplier. Successor to the first-generation single-precision multiplier: configurable exponent/mantissa widths, a shift-add mantissa datapath under an explicit FSM, round-to-nearest-even, special-value handling and exception flags. Sits in the FP unit alongside the other arithmetic blocks, driven by the same en/val start–done style. It is area-lean: one operation in flight, fixed latency.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); significand width M = MAN_W+1
- Derived: W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en  in  1  start request; accepted only when busy=0
- num1  in  W  operand A {sign, exp, frac}
- num2  in  W  operand B
- res  out  W  result, held until next result
- val  out  1  one-cycle pulse: res/flags updated
- busy  out  1  operation in progress; en ignored
- flags  out  4  {invalid, overflow, underflow, inexact}, updated with val, held otherwise

## Operation
- FSM states: IDLE, MUL, RND. busy = (state != IDLE).
- IDLE: on en=1, register operands, classify both, zero accumulator and counter, go to MUL.
- Classification: exp=0 → zero (subnormals flushed, sign kept); exp all-ones & frac=0 → inf; exp all-ones & frac≠0 → NaN; else normal with hidden 1.
- MUL: radix-2 shift-add; one multiplier bit per cycle, counter 0..M-1; 2M-bit product. After M cycles go to RND. Runs for special operands too (fixed latency).
- Exponent: signed EXP_W+2 bits, e = expA + expB − BIAS.
- RND (one cycle): if product bit 2M-1 set, shift right 1, e+1. Keep MAN_W fraction bits, guard, round, sticky (OR of rest). RNE: increment if G & (R | S | lsb). Carry-out from rounding → fraction 0, e+1. Then write res, flags, val=1, go to IDLE.
- Result selection, priority order:
  - Any NaN, or inf×zero → canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0).
  - invalid=1 for inf×zero or any signalling NaN (frac MSB 0).
  - inf×{normal, inf} → inf with sign = signA^signB.
  - Either operand zero → signed zero, flags 0.
  - e ≥ 2^EXP_W−1 → signed inf, overflow=1, inexact=1.
  - e ≤ 0 → signed zero (flush), underflow=1, inexact=1.
  - Otherwise normal result; inexact = G|R|S.
- Sign is always signA^signB except canonical NaN.

## Timing
- Operands captured at edge t (en=1, busy=0). MUL occupies edges t+1..t+M. RND at edge t+M+1 registers res/flags and sets val.
- val is high for exactly the cycle after edge t+M+1. Default M=24 gives result at edge t+25.
- busy is high after edge t through edge t+M+1. It is low in the val cycle, so en in the val cycle is accepted (back-to-back). Throughput: one op per M+2 cycles.
- en while busy=1 is dropped, with no queuing and no effect on the current op.
- Operand inputs need only be stable at the accepting edge.
- Reset (reset=0 at an edge): state IDLE, res=0, val=0, busy=0, flags=0, accumulator/counter cleared. Reset mid-operation aborts; no val for the aborted op. Reset dominates en in the same cycle.

## Test plan
- Basic, default params: 0x3FC00000×0x40000000 → res 0x40400000, flags 0000, val exactly 25 edges after accept. Also 0xC0000000×0x3F000000 → 0xBF800000.
- RNE tie: 0x3F800800×0x3F800800 → 0x3F801000, flags 0001. Also 0x3F800001×0x3F800001 → 0x3F800002, inexact=1.
- Exceptions:
  - 0x7F000000×0x7F000000 → 0x7F800000, flags 0101.
  - 0x0D800000×0x0D800000 → 0x00000000, flags 0011.
  - 0x7F800000×0x00000000 → 0x7FC00000, flags 1000.
  - 0x80000000×0x3F800000 → 0x80000000, flags 0000.
- Handshake: en held high continuously. Ops accepted only at idle edges, one val per op spaced 26 cycles. en pulses while busy produce no extra val; res is held between vals.
- Reset mid-op: reset=0 at edge t+10. All outputs 0, no val. A new op started after reset completes correctly.
- EXP_W=5, MAN_W=10: 0x3E00×0x4000 → 0x4200, val 12 edges after accept. 0x7BFF×0x4000 → 0x7C00, flags 0101.
